// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative radix-2 multiply/divide unit owning HI/LO.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle, followed by a sign-fix phase and a one-cycle HI/LO commit.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start, i_op       request and op select (00 MULT, 01 MULTU,
//                       10 DIV, 11 DIVU); start sampled only in IDLE
//   i_rs_val, i_rt_val  multiplicand/dividend, multiplier/divisor
//   i_flush             abort in-flight operation, HI/LO untouched
//   i_hilo_rd           MFHI/MFLO in decode this cycle
//   o_busy              operation in RUN or FIX
//   o_done              one-cycle pulse while HI/LO take the result
//   o_hi, o_lo          HI/LO architectural registers
//   o_stall_req         decode must stall its HI/LO read
//   o_div_by_zero       sticky divide-by-zero flag
//
// Build option: define MULDIV_DIV_EN to include the divide datapath.
// Without it DIV/DIVU starts are ignored and o_div_by_zero is 0.

module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_rs_val,
    input  logic [WIDTH-1:0] i_rt_val,
    input  logic             i_flush,
    input  logic             i_hilo_rd,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_stall_req,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]    r_cnt;
    logic             r_fix_ph;
    logic             r_is_div;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic             r_cin;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_is_div;
    logic             w_op_ok;
    logic             w_accept;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;
    logic             w_ld_nlo;
    logic             w_ld_nhi;
    logic [WIDTH-1:0] w_ld_q;
    logic [WIDTH-1:0] w_ld_m;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_a;
    logic [WIDTH-1:0] w_mul_q;
    logic [WIDTH-1:0] w_step_a;
    logic [WIDTH-1:0] w_step_q;
    logic             w_commit;

    // Signed ops work on magnitudes; op[0]=0 selects the signed forms.
    assign w_rs_neg = i_rs_val[WIDTH-1] & ~i_op[0];
    assign w_rt_neg = i_rt_val[WIDTH-1] & ~i_op[0];
    assign w_rs_mag = w_rs_neg ? (~i_rs_val + WIDTH'(1)) : i_rs_val;
    assign w_rt_mag = w_rt_neg ? (~i_rt_val + WIDTH'(1)) : i_rt_val;

    // Multiply step: {A,Q} holds the partial product, Q shifts out the
    // multiplier LSB-first.
    assign w_mul_sum = {1'b0, r_a} + (r_q[0] ? {1'b0, r_m} : '0);
    assign w_mul_a   = w_mul_sum[WIDTH:1];
    assign w_mul_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    logic             w_rt_zero;
    logic [WIDTH:0]   w_div_r;
    logic [WIDTH:0]   w_div_d;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_div_a;
    logic [WIDTH-1:0] w_div_q;
    logic             r_dbz;

    assign w_is_div  = i_op[1];
    assign w_op_ok   = 1'b1;
    assign w_rt_zero = (i_rt_val == '0);

    // Restoring divide: A is the partial remainder, Q shifts the
    // dividend out and the quotient bits in.
    assign w_div_r  = {r_a, r_q[WIDTH-1]};
    assign w_div_d  = w_div_r - {1'b0, r_m};
    assign w_div_ok = ~w_div_d[WIDTH];
    assign w_div_a  = w_div_ok ? w_div_d[WIDTH-1:0] : w_div_r[WIDTH-1:0];
    assign w_div_q  = {r_q[WIDTH-2:0], w_div_ok};

    assign w_step_a = r_is_div ? w_div_a : w_mul_a;
    assign w_step_q = r_is_div ? w_div_q : w_mul_q;

    // A zero divisor runs the raw dividend through with no sign fix:
    // the loop then leaves A = rs_val and Q = all ones.
    always_comb begin
        w_ld_q   = w_rt_mag;
        w_ld_m   = w_rs_mag;
        w_ld_nlo = w_rs_neg ^ w_rt_neg;
        w_ld_nhi = w_rs_neg ^ w_rt_neg;
        if (w_is_div) begin
            w_ld_m = w_rt_mag;
            if (w_rt_zero) begin
                w_ld_q   = i_rs_val;
                w_ld_nlo = 1'b0;
                w_ld_nhi = 1'b0;
            end else begin
                w_ld_q   = w_rs_mag;
                w_ld_nhi = w_rs_neg;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dbz <= 1'b0;
        end else if (w_accept && w_is_div) begin
            r_dbz <= w_rt_zero;
        end
    end

    assign o_div_by_zero = r_dbz;
`else
    assign w_is_div = 1'b0;
    assign w_op_ok  = ~i_op[1];
    assign w_step_a = w_mul_a;
    assign w_step_q = w_mul_q;

    always_comb begin
        w_ld_q   = w_rt_mag;
        w_ld_m   = w_rs_mag;
        w_ld_nlo = w_rs_neg ^ w_rt_neg;
        w_ld_nhi = w_rs_neg ^ w_rt_neg;
    end

    assign o_div_by_zero = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) & i_start & ~i_flush & w_op_ok;
    assign w_commit = (r_state == S_DONE) & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                o_busy = 1'b1;
                if (r_fix_ph) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done = ~i_flush;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (i_flush) begin
            w_next = S_IDLE;
        end
    end

    // Sign fix is split into two WIDTH-wide halves so only WIDTH-bit
    // incrementers are needed: low half first, its carry feeds the high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_fix_ph <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_cin    <= 1'b0;
            r_a      <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= CW'(ITER - 1);
                        r_fix_ph <= 1'b0;
                        r_is_div <= w_is_div;
                        r_cin    <= 1'b1;
                        r_a      <= '0;
                        r_q      <= w_ld_q;
                        r_m      <= w_ld_m;
                        r_neg_lo <= w_ld_nlo;
                        r_neg_hi <= w_ld_nhi;
                    end
                end
                S_RUN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                    r_a <= w_step_a;
                    r_q <= w_step_q;
                end
                S_FIX: begin
                    r_fix_ph <= 1'b1;
                    if (!r_fix_ph) begin
                        if (r_neg_lo) begin
                            r_q <= ~r_q + WIDTH'(1);
                        end
                        r_cin <= r_is_div | (r_q == '0);
                    end else if (r_neg_hi) begin
                        r_a <= ~r_a + {{(WIDTH-1){1'b0}}, r_cin};
                    end
                end
                S_DONE: begin
                    if (w_commit) begin
                        r_hi <= r_a;
                        r_lo <= r_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The result is visible on hi/lo during the done cycle itself.
    assign o_hi = w_commit ? r_a : r_hi;
    assign o_lo = w_commit ? r_q : r_lo;

    assign o_stall_req = i_rst_n & i_hilo_rd &
                         (o_busy | (r_state == S_DONE) |
                          ((r_state == S_IDLE) & i_start));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed bench with a cycle-level result model.
// Literal expectations pin the model on the worked examples.

module tb_muldiv_sequencer;

    localparam int W  = 32;
    localparam int IT = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] rs = '0;
    logic [W-1:0] rt = '0;
    logic         flush = 1'b0;
    logic         hilo_rd = 1'b0;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;
    logic         o_stall_req;
    logic         o_div_by_zero;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.WIDTH(W), .ITER(IT)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_op          (op),
        .i_rs_val      (rs),
        .i_rt_val      (rt),
        .i_flush       (flush),
        .i_hilo_rd     (hilo_rd),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_hi          (o_hi),
        .o_lo          (o_lo),
        .o_stall_req   (o_stall_req),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Architectural result of an op, straight from the arithmetic rules.
    function automatic logic [63:0] expect_res(input logic [1:0] o,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = o[0] ? longint'({32'd0, a}) : longint'($signed(a));
        sb = o[0] ? longint'({32'd0, b}) : longint'($signed(b));
        if (!o[1]) begin
            return 64'(sa * sb);
        end
        if (b == '0) begin
            return {a, 32'hFFFF_FFFF};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // m_left: -1 idle, >0 cycles before done, 0 the done cycle.
    int           m_left = -1;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    logic         m_dbz = 1'b0;
    logic         e_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= -1;
            m_hi   <= '0;
            m_lo   <= '0;
            m_dbz  <= 1'b0;
        end else if (flush) begin
            m_left <= -1;
        end else if (m_left == 0) begin
            m_hi   <= p_hi;
            m_lo   <= p_lo;
            m_left <= -1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (start && (!op[1] || DIV_EN)) begin
            {p_hi, p_lo} <= expect_res(op, rs, rt);
            m_left <= IT + 2;
            if (op[1]) begin
                m_dbz <= (rt == '0);
            end
        end
    end

    always @(negedge clk) begin
        e_done = (m_left == 0) && !flush;
        chk("busy", o_busy, m_left > 0);
        chk("done", o_done, e_done);
        chk("hi", o_hi, e_done ? p_hi : m_hi);
        chk("lo", o_lo, e_done ? p_lo : m_lo);
        chk("stall", o_stall_req,
            rst_n && hilo_rd && (m_left >= 0 || start));
        chk("dbz", o_div_by_zero, m_dbz);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit lit,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input bit ed);
        int n;
        n = 0;
        op = o;
        rs = a;
        rt = b;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (o_done) begin
                n = i;
                break;
            end
        end
        chk("latency", n, IT + 3);
        if (lit && n != 0) begin
            chk("hi_lit", o_hi, eh);
            chk("lo_lit", o_lo, el);
            chk("dbz_lit", o_div_by_zero, ed);
        end
        step();
    endtask

    task automatic count_done(input string nm, input int cyc);
        int nd;
        nd = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (o_done) nd++;
        end
        chk(nm, nd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        // Reset with start and hilo_rd high: everything must stay 0.
        start = 1'b1;
        hilo_rd = 1'b1;
        @(negedge clk);
        chk("rst_stall", o_stall_req, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_hi", o_hi, 32'h0);
        chk("rst_lo", o_lo, 32'h0);
        step();
        start = 1'b0;
        hilo_rd = 1'b0;
        rst_n = 1'b1;
        step();

        // hilo_rd held from start; a second start while busy is ignored.
        hilo_rd = 1'b1;
        op = 2'b01;
        rs = 32'hFFFF_FFFF;
        rt = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        chk("stall_idle_start", o_stall_req, 1'b1);
        step();
        start = 1'b0;
        repeat (3) step();
        op = 2'b00;
        rs = 32'd5;
        rt = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        for (int i = 5; i <= 60; i++) begin
            @(negedge clk);
            if (o_done) begin
                n = i;
                break;
            end
        end
        chk("latency_hilo", n, 35);
        chk("stall_done", o_stall_req, 1'b1);
        chk("multu_hi", o_hi, 32'hFFFF_FFFE);
        chk("multu_lo", o_lo, 32'h0000_0001);
        step();
        @(negedge clk);
        chk("stall_after", o_stall_req, 1'b0);
        hilo_rd = 1'b0;
        step();

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1,
               32'h4000_0000, 32'h0, 1'b0);
        run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, '0, '0, 1'b0);
        run_op(2'b01, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'h0, 32'h0, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
               32'h0, 32'h1, 1'b0);

        // Flush mid-run: back to idle, no done, HI/LO keep 0 / 1.
        op = 2'b01;
        rs = 32'd6;
        rt = 32'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", o_busy, 1'b0);
        chk("flush_hi", o_hi, 32'h0);
        chk("flush_lo", o_lo, 32'h1);
        count_done("flush_no_done", 40);
        step();

        // Flush beats start in the same cycle.
        op = 2'b01;
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_start_busy", o_busy, 1'b0);
        step();

`ifdef MULDIV_DIV_EN
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b11, 32'd100, 32'd0, 1'b1,
               32'd100, 32'hFFFF_FFFF, 1'b1);
        run_op(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
               32'h0, 32'h8000_0000, 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1,
               32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b1,
               32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, '0, '0, 1'b0);
`else
        run_op(2'b00, 32'd2, 32'd3, 1'b1, 32'h0, 32'd6, 1'b0);
        op = 2'b10;
        rs = 32'd9;
        rt = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("nodiv_busy", o_busy, 1'b0);
        end
        chk("nodiv_hi", o_hi, 32'h0);
        chk("nodiv_lo", o_lo, 32'd6);
        count_done("nodiv_no_done", 40);
        step();
`endif

        // Reset ten cycles into a run: outputs clear, no done afterwards.
        op = 2'b01;
        rs = 32'h0001_0000;
        rt = 32'h0001_0000;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstrun_busy", o_busy, 1'b0);
        chk("rstrun_hi", o_hi, 32'h0);
        chk("rstrun_lo", o_lo, 32'h0);
        chk("rstrun_dbz", o_div_by_zero, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        count_done("rstrun_no_done", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO register width.
REQ-002 Parameter ITER, default 32: iterations per operation; SHALL equal WIDTH.
REQ-003 clk  input  1: single clock; all state changes on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 start  input  1: request operation; sampled only in IDLE.
REQ-006 op  input  2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 rs_val  input  WIDTH: multiplicand or dividend.
REQ-008 rt_val  input  WIDTH: multiplier or divisor.
REQ-009 flush  input  1: pipeline flush; aborts the in-flight operation.
REQ-010 hilo_rd  input  1: MFHI/MFLO in decode this cycle.
REQ-011 busy  output  1: operation in progress (RUN or FIX).
REQ-012 done  output  1: one-cycle pulse when HI/LO are updated.
REQ-013 hi  output  WIDTH: HI register (product upper half or remainder).
REQ-014 lo  output  WIDTH: LO register (product lower half or quotient).
REQ-015 stall_req  output  1: pipeline stall request.
REQ-016 div_by_zero  output  1: sticky flag, set by a divide with rt_val == 0.

Function
REQ-017 FSM states are IDLE, RUN, FIX and DONE; no other state is reachable.
REQ-018 IDLE with start=1 SHALL latch op/rs_val/rt_val, load the iteration counter with ITER-1 and go to RUN.
REQ-019 Signed ops (MULT, DIV) SHALL latch operand magnitudes plus a result-sign bit and a remainder-sign bit (remainder sign = dividend sign).
REQ-020 RUN: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide); counter decrements; counter == 0 -> FIX.
REQ-021 FIX: apply two's-complement negation where the sign bits require it -> DONE.
REQ-022 DONE: write hi/lo, pulse done for exactly one cycle -> IDLE.
REQ-023 Latency: start sampled at edge N -> done high in the cycle after edge N+ITER+2 (34 cycles for ITER=32); hi/lo valid in that same cycle.
REQ-024 busy SHALL be high in RUN and FIX only; start while not in IDLE SHALL be ignored.
REQ-025 stall_req = hilo_rd AND (busy OR state==DONE OR (state==IDLE AND start)), combinationally.
REQ-026 flush in any state SHALL force IDLE at the next edge, leave hi/lo unchanged, and suppress done; flush has priority over start in the same cycle.
REQ-027 Divide with rt_val == 0: complete with normal latency; hi = rs_val, lo = all ones, div_by_zero set.
REQ-028 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0 with no flag.
REQ-029 Multiply results are full 2*WIDTH products; no truncation or saturation.
REQ-030 div_by_zero SHALL clear only on reset or on the start of the next accepted divide.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE; hi, lo and the counter become 0; busy, done, div_by_zero become 0.
REQ-032 Reset asserted mid-operation SHALL discard the operation; no done pulse follows release.
REQ-033 stall_req SHALL be 0 while rst_n is low.

Configuration
REQ-034 With macro MULDIV_DIV_EN defined, all four ops are supported as specified.
REQ-035 Without MULDIV_DIV_EN, the divide datapath is absent; start with op[1]=1 SHALL be ignored (no busy, no done, hi/lo unchanged) and div_by_zero SHALL be tied to 0.

Verification
REQ-036 Reset mid-RUN (cycle 10 after start) -> all outputs 0, state IDLE, no done within 40 cycles of release.
REQ-037 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at 34 cycles; hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-038 MULT -3 x 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-039 DIVU 100 / 0 -> hi = 100, lo = 0xFFFFFFFF, div_by_zero = 1; next DIVU 100 / 7 -> flag clears, lo = 14, hi = 2.
REQ-040 hilo_rd held high from start -> stall_req high through the done cycle, low the cycle after; second start while busy ignored.
REQ-041 flush at cycle 5 of a MULTU -> IDLE next edge, no done, hi/lo keep prior values; build without MULDIV_DIV_EN, DIV start -> busy stays 0.
